// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, immediate formats,
// decode-stage FSM states and immediate extraction helpers.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} imm_fmt_e;
  typedef enum logic [1:0] {WARMUP, RUN, BUBBLE} dec_state_e;

  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_LUI, OPC_AUIPC:             return IMM_U;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

  // Returns the 32-bit sign-extended immediate; callers widen to XLEN.
  function automatic logic [31:0] imm_of(input logic [31:0] instr);
    case (imm_fmt_of(instr[6:0]))
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic is_rv32i_opcode(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_BRANCH, OPC_JAL,
      OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_MISC_MEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fwd_resolve.sv
// Combinational operand resolution: current writeback beats the history,
// younger history beats older, register file is the fallback, x0 is always 0.
module fwd_resolve
  import riscv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 3
) (
  input  logic [REG_ADDR_W-1:0]                                    src_addr,
  input  logic [XLEN-1:0]                                          rf_data,
  input  logic                                                     fwd_valid,
  input  logic [REG_ADDR_W-1:0]                                    fwd_addr,
  input  logic [XLEN-1:0]                                          fwd_data,
  input  logic [((FWD_DEPTH > 1) ? FWD_DEPTH-1 : 1)-1:0]                   hist_valid,
  input  logic [((FWD_DEPTH > 1) ? FWD_DEPTH-1 : 1)-1:0][REG_ADDR_W-1:0]   hist_addr,
  input  logic [((FWD_DEPTH > 1) ? FWD_DEPTH-1 : 1)-1:0][XLEN-1:0]         hist_data,
  output logic [XLEN-1:0]                                          data
);

  localparam int HIST_N = (FWD_DEPTH > 1) ? FWD_DEPTH-1 : 1;

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    data = rf_data;
    for (int i = HIST_N-1; i >= 0; i--) begin
      if (i < FWD_DEPTH-1 && hist_valid[i] && hist_addr[i] == src_addr)
        data = hist_data[i];
    end
    if (fwd_valid && fwd_addr == src_addr)
      data = fwd_data;
    if (src_addr == '0)
      data = '0;
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// RV32I decode stage with valid/ready on both sides and writeback forwarding.
// Optional load-use bubble insertion: define DECODE_LOAD_USE_STALL_EN.
module instr_decode_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int REG_ADDR_W    = 5,
  parameter int FWD_DEPTH     = 3,
  parameter int WARMUP_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  flush_i,
  input  logic                  instr_valid_i,
  output logic                  instr_ready_o,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [31:0]           instr_i,
  output logic [REG_ADDR_W-1:0] rs1_addr_o,
  output logic [REG_ADDR_W-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic                  fwd_valid_i,
  input  logic [REG_ADDR_W-1:0] fwd_rd_addr_i,
  input  logic [XLEN-1:0]       fwd_rd_data_i,
  output logic                  dec_valid_o,
  input  logic                  dec_ready_i,
  output logic [XLEN-1:0]       pc_o,
  output logic [6:0]            opcode_o,
  output logic [2:0]            funct3_o,
  output logic [6:0]            funct7_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic [XLEN-1:0]       imm_o,
  output logic [XLEN-1:0]       rs1_data_o,
  output logic [XLEN-1:0]       rs2_data_o,
  output logic                  illegal_o
);

  localparam int HIST_N = (FWD_DEPTH > 1) ? FWD_DEPTH-1 : 1;
  localparam int CNT_W  = $clog2(WARMUP_CYCLES + 2);

  dec_state_e                          state;
  logic [CNT_W-1:0]                    warm_cnt;
  logic [HIST_N-1:0]                   hist_valid;
  logic [HIST_N-1:0][REG_ADDR_W-1:0]   hist_addr;
  logic [HIST_N-1:0][XLEN-1:0]         hist_data;
  logic [REG_ADDR_W-1:0]               held_rs1;
  logic [REG_ADDR_W-1:0]               held_rs2;
  logic [XLEN-1:0]                     rs1_res;
  logic [XLEN-1:0]                     rs2_res;
  logic                                in_hs;
  logic                                out_hs;
  logic                                stalled;
  logic                                loaduse;

  assign rs1_addr_o = instr_i[15 +: REG_ADDR_W];
  assign rs2_addr_o = instr_i[20 +: REG_ADDR_W];

`ifdef DECODE_LOAD_USE_STALL_EN
  // Held load is leaving this cycle while its consumer is waiting at the input.
  assign loaduse = dec_valid_o && dec_ready_i && instr_valid_i && !flush_i &&
                   opcode_o == OPC_LOAD && rd_addr_o != '0 &&
                   (rs1_addr_o == rd_addr_o || rs2_addr_o == rd_addr_o);
`else
  assign loaduse = 1'b0;
`endif

  assign instr_ready_o = (state == RUN) && (!dec_valid_o || dec_ready_i) && !loaduse;
  assign in_hs         = instr_valid_i && instr_ready_o && !flush_i;
  assign out_hs        = dec_valid_o && dec_ready_i;
  assign stalled       = dec_valid_o && !dec_ready_i;

  fwd_resolve #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .FWD_DEPTH(FWD_DEPTH)) u_fwd_rs1 (
    .src_addr(rs1_addr_o), .rf_data(rs1_data_i),
    .fwd_valid(fwd_valid_i), .fwd_addr(fwd_rd_addr_i), .fwd_data(fwd_rd_data_i),
    .hist_valid(hist_valid), .hist_addr(hist_addr), .hist_data(hist_data),
    .data(rs1_res)
  );

  fwd_resolve #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .FWD_DEPTH(FWD_DEPTH)) u_fwd_rs2 (
    .src_addr(rs2_addr_o), .rf_data(rs2_data_i),
    .fwd_valid(fwd_valid_i), .fwd_addr(fwd_rd_addr_i), .fwd_data(fwd_rd_data_i),
    .hist_valid(hist_valid), .hist_addr(hist_addr), .hist_data(hist_data),
    .data(rs2_res)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= WARMUP;
      warm_cnt <= '0;
    end else begin
      case (state)
        WARMUP: begin
          if (int'(warm_cnt) + 1 >= WARMUP_CYCLES) state <= RUN;
          else warm_cnt <= warm_cnt + 1'b1;
        end
        RUN:     if (loaduse) state <= BUBBLE;
        BUBBLE:  state <= RUN;
        default: state <= WARMUP;
      endcase
    end
  end

  // Writeback history keeps shifting through flushes and stalls.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hist_valid <= '0;
      hist_addr  <= '0;
      hist_data  <= '0;
    end else begin
      hist_valid[0] <= fwd_valid_i;
      hist_addr[0]  <= fwd_rd_addr_i;
      hist_data[0]  <= fwd_rd_data_i;
      for (int i = 1; i < HIST_N; i++) begin
        hist_valid[i] <= hist_valid[i-1];
        hist_addr[i]  <= hist_addr[i-1];
        hist_data[i]  <= hist_data[i-1];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      dec_valid_o <= 1'b0;
      pc_o        <= '0;
      opcode_o    <= '0;
      funct3_o    <= '0;
      funct7_o    <= '0;
      rd_addr_o   <= '0;
      imm_o       <= '0;
      rs1_data_o  <= '0;
      rs2_data_o  <= '0;
      illegal_o   <= 1'b0;
      held_rs1    <= '0;
      held_rs2    <= '0;
    end else if (flush_i) begin
      dec_valid_o <= 1'b0;
    end else if (in_hs) begin
      dec_valid_o <= 1'b1;
      pc_o        <= pc_i;
      opcode_o    <= instr_i[6:0];
      funct3_o    <= instr_i[14:12];
      funct7_o    <= instr_i[31:25];
      rd_addr_o   <= instr_i[7 +: REG_ADDR_W];
      imm_o       <= XLEN'($signed(imm_of(instr_i)));
      rs1_data_o  <= rs1_res;
      rs2_data_o  <= rs2_res;
      illegal_o   <= !is_rv32i_opcode(instr_i[6:0]);
      held_rs1    <= rs1_addr_o;
      held_rs2    <= rs2_addr_o;
    end else begin
      if (out_hs) dec_valid_o <= 1'b0;
      // A stalled instruction must not miss results that retire while it waits.
      if (stalled && fwd_valid_i) begin
        if (held_rs1 != '0 && held_rs1 == fwd_rd_addr_i) rs1_data_o <= fwd_rd_data_i;
        if (held_rs2 != '0 && held_rs2 == fwd_rd_addr_i) rs2_data_o <= fwd_rd_data_i;
      end
    end
  end

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed self-checking bench for instr_decode_pipe; load-use expectations
// follow DECODE_LOAD_USE_STALL_EN.
module tb_instr_decode_pipe;

  logic        clk = 1'b0;
  logic        reset_i, flush_i, instr_valid_i, instr_ready_o;
  logic [31:0] pc_i, instr_i;
  logic [4:0]  rs1_addr_o, rs2_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i;
  logic        fwd_valid_i;
  logic [4:0]  fwd_rd_addr_i;
  logic [31:0] fwd_rd_data_i;
  logic        dec_valid_o, dec_ready_i;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o, funct7_o;
  logic [2:0]  funct3_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] imm_o, rs1_data_o, rs2_data_o;
  logic        illegal_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_decode_pipe #(.XLEN(32), .REG_ADDR_W(5), .FWD_DEPTH(3), .WARMUP_CYCLES(2)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .pc_i(pc_i), .instr_i(instr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .fwd_valid_i(fwd_valid_i), .fwd_rd_addr_i(fwd_rd_addr_i), .fwd_rd_data_i(fwd_rd_data_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .pc_o(pc_o), .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .rd_addr_o(rd_addr_o), .imm_o(imm_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .illegal_o(illegal_o)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    tick;
    tick;
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dec_valid: got %b expected 0", dec_valid_o); end
    n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b expected 0", instr_ready_o); end
    n_checks++; if (imm_o !== 32'h0 || pc_o !== 32'h0 || illegal_o !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_regs: imm %h pc %h illegal %b expected all 0", imm_o, pc_o, illegal_o); end
    reset_i = 1'b0;
    #1;
    n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL warmup_cycle0: got %b expected 0", instr_ready_o); end
    tick;
    n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL warmup_cycle1: got %b expected 0", instr_ready_o); end
    tick;
    n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL warmup_done: got %b expected 1", instr_ready_o); end
  endtask

  task automatic test_basic;
    instr_valid_i = 1'b1; instr_i = 32'h00500093; pc_i = 32'h100;
    #1;
    n_checks++; if (rs1_addr_o !== 5'd0 || rs2_addr_o !== 5'd5) begin n_fail++; $display("[TB] FAIL rs_addr_comb: got %0d/%0d expected 0/5", rs1_addr_o, rs2_addr_o); end
    tick;
    instr_valid_i = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL addi_valid: got %b expected 1", dec_valid_o); end
    n_checks++; if (imm_o !== 32'd5) begin n_fail++; $display("[TB] FAIL addi_imm: got %h expected 5", imm_o); end
    n_checks++; if (rd_addr_o !== 5'd1 || opcode_o !== 7'h13) begin n_fail++; $display("[TB] FAIL addi_fields: rd %0d op %h expected 1/13", rd_addr_o, opcode_o); end
    n_checks++; if (pc_o !== 32'h100) begin n_fail++; $display("[TB] FAIL addi_pc: got %h expected 100", pc_o); end
  endtask

  task automatic test_fwd_same_cycle;
    instr_valid_i = 1'b1; instr_i = 32'h00318233; pc_i = 32'h104;
    rs1_data_i = 32'h0; rs2_data_i = 32'h0;
    fwd_valid_i = 1'b1; fwd_rd_addr_i = 5'd3; fwd_rd_data_i = 32'hAAAA;
    tick;
    n_checks++; if (rs1_data_o !== 32'hAAAA || rs2_data_o !== 32'hAAAA) begin n_fail++; $display("[TB] FAIL fwd_now: got %h/%h expected aaaa/aaaa", rs1_data_o, rs2_data_o); end
    n_checks++; if (rd_addr_o !== 5'd4 || imm_o !== 32'h0 || pc_o !== 32'h104) begin n_fail++; $display("[TB] FAIL add_fields: rd %0d imm %h pc %h expected 4/0/104", rd_addr_o, imm_o, pc_o); end
    instr_i = 32'h00000233; fwd_rd_addr_i = 5'd0; fwd_rd_data_i = 32'h5555;
    rs1_data_i = 32'h77; rs2_data_i = 32'h77;
    tick;
    instr_valid_i = 1'b0; fwd_valid_i = 1'b0;
    n_checks++; if (rs1_data_o !== 32'h0 || rs2_data_o !== 32'h0) begin n_fail++; $display("[TB] FAIL x0_source: got %h/%h expected 0/0", rs1_data_o, rs2_data_o); end
  endtask

  task automatic test_back_to_back;
    fwd_valid_i = 1'b1; fwd_rd_addr_i = 5'd5; fwd_rd_data_i = 32'd1;
    tick;
    fwd_rd_data_i = 32'd2;
    tick;
    fwd_valid_i = 1'b0;
    instr_valid_i = 1'b1; instr_i = 32'h00528533; rs1_data_i = 32'h99; rs2_data_i = 32'h99;
    tick;
    n_checks++; if (rs1_data_o !== 32'd2 || rs2_data_o !== 32'd2) begin n_fail++; $display("[TB] FAIL youngest_wins: got %h/%h expected 2/2", rs1_data_o, rs2_data_o); end
    tick;
    n_checks++; if (rs1_data_o !== 32'd2 || dec_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL hist_oldest: got %h valid %b expected 2/1", rs1_data_o, dec_valid_o); end
    tick;
    instr_valid_i = 1'b0;
    n_checks++; if (rs1_data_o !== 32'h99 || rs2_data_o !== 32'h99) begin n_fail++; $display("[TB] FAIL hist_aged_out: got %h/%h expected 99/99", rs1_data_o, rs2_data_o); end
  endtask

  task automatic test_hold_refresh;
    instr_valid_i = 1'b1; instr_i = 32'h40728333; rs1_data_i = 32'h11; rs2_data_i = 32'h22;
    dec_ready_i = 1'b1;
    tick;
    instr_valid_i = 1'b0; dec_ready_i = 1'b0;
    #1;
    n_checks++; if (rs1_data_o !== 32'h11 || rs2_data_o !== 32'h22 || funct7_o !== 7'h20) begin n_fail++; $display("[TB] FAIL sub_capture: %h/%h f7 %h expected 11/22/20", rs1_data_o, rs2_data_o, funct7_o); end
    n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_ready: got %b expected 0", instr_ready_o); end
    fwd_valid_i = 1'b1; fwd_rd_addr_i = 5'd7; fwd_rd_data_i = 32'h1234;
    tick;
    fwd_valid_i = 1'b0;
    n_checks++; if (rs2_data_o !== 32'h1234 || rs1_data_o !== 32'h11 || dec_valid_o !== 1'b1) begin n_fail++; $display("[TB] FAIL held_refresh: %h/%h valid %b expected 11/1234/1", rs1_data_o, rs2_data_o, dec_valid_o); end
    dec_ready_i = 1'b1;
    tick;
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL drain: got %b expected 0", dec_valid_o); end
  endtask

  task automatic test_imm_formats;
    logic [31:0] instrs [4] = '{32'hFE20AE23, 32'h123451B7, 32'hFE000CE3, 32'hFFFFFFFF};
    logic [31:0] imms   [4] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFF8, 32'h0};
    logic        ills   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      instr_valid_i = 1'b1; instr_i = instrs[i];
      tick;
      n_checks++; if (imm_o !== imms[i] || illegal_o !== ills[i]) begin n_fail++; $display("[TB] FAIL imm_fmt[%0d]: imm %h illegal %b expected %h/%b", i, imm_o, illegal_o, imms[i], ills[i]); end
    end
    instr_valid_i = 1'b0;
    tick;
  endtask

  task automatic test_load_use;
    rs1_data_i = 32'h0; rs2_data_i = 32'h0;
    instr_valid_i = 1'b1; instr_i = 32'h0000A403;
    tick;
    n_checks++; if (opcode_o !== 7'h03 || rd_addr_o !== 5'd8) begin n_fail++; $display("[TB] FAIL lw_held: op %h rd %0d expected 03/8", opcode_o, rd_addr_o); end
    instr_i = 32'h008404B3;
    #1;
`ifdef DECODE_LOAD_USE_STALL_EN
    n_checks++; if (instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL loaduse_refuse: got %b expected 0", instr_ready_o); end
    tick;
    n_checks++; if (dec_valid_o !== 1'b0 || instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL bubble: valid %b ready %b expected 0/0", dec_valid_o, instr_ready_o); end
    fwd_valid_i = 1'b1; fwd_rd_addr_i = 5'd8; fwd_rd_data_i = 32'h5A5A;
    tick;
    fwd_valid_i = 1'b0;
    #1;
    n_checks++; if (dec_valid_o !== 1'b0 || instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL after_bubble: valid %b ready %b expected 0/1", dec_valid_o, instr_ready_o); end
    tick;
    instr_valid_i = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b1 || rd_addr_o !== 5'd9 || rs1_data_o !== 32'h5A5A || rs2_data_o !== 32'h5A5A) begin n_fail++; $display("[TB] FAIL add_after_load: valid %b rd %0d ops %h/%h expected 1/9/5a5a/5a5a", dec_valid_o, rd_addr_o, rs1_data_o, rs2_data_o); end
`else
    n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL no_stall_ready: got %b expected 1", instr_ready_o); end
    tick;
    instr_valid_i = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b1 || rd_addr_o !== 5'd9) begin n_fail++; $display("[TB] FAIL no_bubble: valid %b rd %0d expected 1/9", dec_valid_o, rd_addr_o); end
`endif
    tick;
  endtask

  task automatic test_flush;
    instr_valid_i = 1'b1; instr_i = 32'h00500093;
    tick;
    instr_i = 32'h008000EF; flush_i = 1'b1;
    #1;
    n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_ready: got %b expected 1", instr_ready_o); end
    tick;
    flush_i = 1'b0; instr_valid_i = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_kill: got %b expected 0", dec_valid_o); end
    tick;
    n_checks++; if (dec_valid_o !== 1'b0 || opcode_o !== 7'h13) begin n_fail++; $display("[TB] FAIL flush_dropped: valid %b op %h expected 0/13", dec_valid_o, opcode_o); end
    instr_valid_i = 1'b1;
    tick;
    instr_valid_i = 1'b0;
    n_checks++; if (dec_valid_o !== 1'b1 || imm_o !== 32'd8 || opcode_o !== 7'h6F || rd_addr_o !== 5'd1) begin n_fail++; $display("[TB] FAIL jal: valid %b imm %h op %h rd %0d expected 1/8/6f/1", dec_valid_o, imm_o, opcode_o, rd_addr_o); end
  endtask

  task automatic test_reset_midop;
    instr_valid_i = 1'b1; instr_i = 32'h123451B7; dec_ready_i = 1'b0;
    tick;
    instr_valid_i = 1'b0; reset_i = 1'b1;
    tick;
    reset_i = 1'b0; dec_ready_i = 1'b1;
    #1;
    n_checks++; if (dec_valid_o !== 1'b0 || imm_o !== 32'h0 || opcode_o !== 7'h0 || instr_ready_o !== 1'b0) begin n_fail++; $display("[TB] FAIL midop_reset: valid %b imm %h op %h ready %b expected 0/0/0/0", dec_valid_o, imm_o, opcode_o, instr_ready_o); end
    tick;
    tick;
    n_checks++; if (instr_ready_o !== 1'b1) begin n_fail++; $display("[TB] FAIL rewarmup: got %b expected 1", instr_ready_o); end
  endtask

  initial begin
    reset_i = 1'b1; flush_i = 1'b0; instr_valid_i = 1'b0; pc_i = 32'h0; instr_i = 32'h0;
    rs1_data_i = 32'h0; rs2_data_i = 32'h0;
    fwd_valid_i = 1'b0; fwd_rd_addr_i = 5'd0; fwd_rd_data_i = 32'h0;
    dec_ready_i = 1'b1;
    test_reset;
    test_basic;
    test_fwd_same_cycle;
    test_back_to_back;
    test_hold_refresh;
    test_imm_formats;
    test_load_use;
    test_flush;
    test_reset_midop;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
